// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared types and constants for the 5-stage CPU pipeline
package cpu_pkg;

   typedef enum logic [1:0] {
      RUN    = 2'd0,
      DRAIN  = 2'd1,
      HALTED = 2'd2
   } state_t;

   localparam logic [3:0]  REG_ZERO = 4'd0;
   localparam logic [15:0] NOP      = 16'h0000;

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - event counter that sticks at all-ones
module sat_counter #(
   parameter int W = 16
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         inc,
   output logic [W-1:0] cnt
);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt <= '0;
      end else if (inc && (cnt != '1)) begin
         cnt <= cnt + W'(1);
      end
   end

endmodule

// File: rtl/pipe_ctrl.sv
// rtl/pipe_ctrl.sv - load-use stall, branch squash, memory freeze and halt drain control
module pipe_ctrl
   import cpu_pkg::*;
#(
   parameter int DRAIN_CYCLES = 3,
   parameter int CNT_W        = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [3:0]       rdReg1_ID,
   input  logic [3:0]       rdReg2_ID,
   input  logic             re1_ID,
   input  logic             re2_ID,
   input  logic [3:0]       wrReg_EX,
   input  logic             memRd_EX,
   input  logic             br_taken_EX,
   input  logic             halt_ID,
   input  logic             mem_busy,
   output logic             stall_front,
   output logic             stall_all,
   output logic             flush_IFID,
   output logic             flush_IDEX,
   output logic             halted,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] flush_cnt
);

   localparam int DW = (DRAIN_CYCLES > 2) ? $clog2(DRAIN_CYCLES) : 1;

   state_t        state;
   state_t        nextState;
   logic [DW-1:0] drainCnt;
   logic [DW-1:0] nextDrainCnt;
   logic          loadUse;
   logic          stallInc;
   logic          flushInc;

   // Register 0 is hardwired, so a load targeting it never creates a real dependency.
   assign loadUse = memRd_EX && (wrReg_EX != REG_ZERO) &&
                    ((re1_ID && (rdReg1_ID == wrReg_EX)) ||
                     (re2_ID && (rdReg2_ID == wrReg_EX)));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= RUN;
         drainCnt <= '0;
      end else begin
         state    <= nextState;
         drainCnt <= nextDrainCnt;
      end
   end

   always_comb begin
      nextState    = state;
      nextDrainCnt = drainCnt;
      stall_front  = 1'b0;
      stall_all    = 1'b0;
      flush_IFID   = 1'b0;
      flush_IDEX   = 1'b0;
      stallInc     = 1'b0;
      flushInc     = 1'b0;
      case (state)
         RUN: begin
            if (mem_busy) begin
               stall_all   = 1'b1;
               stall_front = 1'b1;
            end else if (br_taken_EX) begin
               // ID holds a wrong-path instruction, so its hazards and HLT are moot.
               flush_IFID = 1'b1;
               flush_IDEX = 1'b1;
               flushInc   = 1'b1;
            end else if (loadUse) begin
               stall_front = 1'b1;
               flush_IDEX  = 1'b1;
               stallInc    = 1'b1;
            end else if (halt_ID) begin
               nextState    = DRAIN;
               nextDrainCnt = DW'(DRAIN_CYCLES - 1);
            end
         end
         DRAIN: begin
            stall_front = 1'b1;
            flush_IDEX  = 1'b1;
            if (mem_busy) begin
               stall_all = 1'b1;
            end else if (drainCnt == '0) begin
               nextState = HALTED;
            end else begin
               nextDrainCnt = drainCnt - DW'(1);
            end
         end
         HALTED: begin
            stall_front = 1'b1;
            flush_IDEX  = 1'b1;
         end
         default: begin
            nextState = RUN;
         end
      endcase
   end

   assign halted = (state == HALTED);

   sat_counter #(.W(CNT_W)) uStallCnt (
      .clk (clk),
      .rst (rst),
      .inc (stallInc),
      .cnt (stall_cnt)
   );

   sat_counter #(.W(CNT_W)) uFlushCnt (
      .clk (clk),
      .rst (rst),
      .inc (flushInc),
      .cnt (flush_cnt)
   );

endmodule

// File: tb/tb_pipe_ctrl.sv
// tb/tb_pipe_ctrl.sv - directed scoreboard bench for pipe_ctrl
module tb_pipe_ctrl;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [3:0]  rdReg1_ID = '0;
   logic [3:0]  rdReg2_ID = '0;
   logic        re1_ID = 1'b0;
   logic        re2_ID = 1'b0;
   logic [3:0]  wrReg_EX = '0;
   logic        memRd_EX = 1'b0;
   logic        br_taken_EX = 1'b0;
   logic        halt_ID = 1'b0;
   logic        mem_busy = 1'b0;
   logic        stall_front;
   logic        stall_all;
   logic        flush_IFID;
   logic        flush_IDEX;
   logic        halted;
   logic [15:0] stall_cnt;
   logic [15:0] flush_cnt;

   int passCnt = 0;
   int totalCnt = 0;

   typedef struct {
      string       tag;
      logic        sf;
      logic        sa;
      logic        fi;
      logic        fd;
      logic        h;
      logic [15:0] sc;
      logic [15:0] fc;
   } exp_t;

   exp_t sb[$];

   pipe_ctrl #(.DRAIN_CYCLES(3), .CNT_W(16)) dut (
      .clk         (clk),
      .rst         (rst),
      .rdReg1_ID   (rdReg1_ID),
      .rdReg2_ID   (rdReg2_ID),
      .re1_ID      (re1_ID),
      .re2_ID      (re2_ID),
      .wrReg_EX    (wrReg_EX),
      .memRd_EX    (memRd_EX),
      .br_taken_EX (br_taken_EX),
      .halt_ID     (halt_ID),
      .mem_busy    (mem_busy),
      .stall_front (stall_front),
      .stall_all   (stall_all),
      .flush_IFID  (flush_IFID),
      .flush_IDEX  (flush_IDEX),
      .halted      (halted),
      .stall_cnt   (stall_cnt),
      .flush_cnt   (flush_cnt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      totalCnt++;
      assert (obs === exp) passCnt++;
      else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
   endtask

   task automatic drv(input logic m, input logic [3:0] wr, input logic [3:0] r1,
                      input logic [3:0] r2, input logic e1, input logic e2,
                      input logic br, input logic hl, input logic busy);
      memRd_EX    = m;
      wrReg_EX    = wr;
      rdReg1_ID   = r1;
      rdReg2_ID   = r2;
      re1_ID      = e1;
      re2_ID      = e2;
      br_taken_EX = br;
      halt_ID     = hl;
      mem_busy    = busy;
   endtask

   task automatic idle();
      drv(1'b0, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic push(input string tag, input logic sf, input logic sa, input logic fi,
                       input logic fd, input logic h, input logic [15:0] sc,
                       input logic [15:0] fc);
      exp_t e;
      e.tag = tag;
      e.sf = sf;
      e.sa = sa;
      e.fi = fi;
      e.fd = fd;
      e.h = h;
      e.sc = sc;
      e.fc = fc;
      sb.push_back(e);
   endtask

   task automatic sample();
      exp_t e;
      #1;
      e = sb.pop_front();
      chk({e.tag, ".stall_front"}, 16'(stall_front), 16'(e.sf));
      chk({e.tag, ".stall_all"},   16'(stall_all),   16'(e.sa));
      chk({e.tag, ".flush_IFID"},  16'(flush_IFID),  16'(e.fi));
      chk({e.tag, ".flush_IDEX"},  16'(flush_IDEX),  16'(e.fd));
      chk({e.tag, ".halted"},      16'(halted),      16'(e.h));
      chk({e.tag, ".stall_cnt"},   stall_cnt,        e.sc);
      chk({e.tag, ".flush_cnt"},   flush_cnt,        e.fc);
   endtask

   task automatic doReset();
      @(negedge clk);
      idle();
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
   endtask

   initial begin
      #2;
      push("reset", 0, 0, 0, 0, 0, 16'd0, 16'd0);
      sample();
      @(negedge clk);
      rst = 1'b0;

      @(negedge clk); idle();
      push("idle", 0, 0, 0, 0, 0, 16'd0, 16'd0); sample();
      @(negedge clk); drv(1, 4'd5, 4'd0, 4'd5, 0, 1, 0, 0, 0);
      push("lu_r2", 1, 0, 0, 1, 0, 16'd0, 16'd0); sample();
      @(negedge clk); idle();
      push("lu_after", 0, 0, 0, 0, 0, 16'd1, 16'd0); sample();
      @(negedge clk); drv(1, 4'd0, 4'd0, 4'd0, 1, 1, 0, 0, 0);
      push("lu_r0", 0, 0, 0, 0, 0, 16'd1, 16'd0); sample();
      @(negedge clk); drv(1, 4'd7, 4'd7, 4'd7, 0, 0, 0, 0, 0);
      push("lu_noread", 0, 0, 0, 0, 0, 16'd1, 16'd0); sample();
      @(negedge clk); drv(1, 4'd9, 4'd9, 4'd0, 1, 0, 0, 0, 0);
      push("lu_r1", 1, 0, 0, 1, 0, 16'd1, 16'd0); sample();
      @(negedge clk); drv(1, 4'd5, 4'd5, 4'd0, 1, 0, 1, 1, 0);
      push("br_prio", 0, 0, 1, 1, 0, 16'd2, 16'd0); sample();
      @(negedge clk); idle();
      push("br_after", 0, 0, 0, 0, 0, 16'd2, 16'd1); sample();

      for (int i = 0; i < 4; i++) begin
         @(negedge clk); drv(1, 4'd3, 4'd3, 4'd0, 1, 0, 0, 0, 1);
         push("busy_lu", 1, 1, 0, 0, 0, 16'd2, 16'd1); sample();
      end
      @(negedge clk); drv(1, 4'd3, 4'd3, 4'd0, 1, 0, 0, 0, 0);
      push("busy_drop", 1, 0, 0, 1, 0, 16'd2, 16'd1); sample();
      @(negedge clk); idle();
      push("busy_done", 0, 0, 0, 0, 0, 16'd3, 16'd1); sample();
      @(negedge clk); drv(0, 4'd0, 4'd0, 4'd0, 0, 0, 1, 0, 1);
      push("busy_br", 1, 1, 0, 0, 0, 16'd3, 16'd1); sample();
      @(negedge clk); drv(0, 4'd0, 4'd0, 4'd0, 0, 0, 1, 0, 0);
      push("br2", 0, 0, 1, 1, 0, 16'd3, 16'd1); sample();

      @(negedge clk); drv(0, 4'd0, 4'd0, 4'd0, 0, 0, 0, 1, 0);
      push("halt_id", 0, 0, 0, 0, 0, 16'd3, 16'd2); sample();
      for (int i = 0; i < 3; i++) begin
         @(negedge clk); idle();
         push("drain", 1, 0, 0, 1, 0, 16'd3, 16'd2); sample();
      end
      @(negedge clk); drv(1, 4'd5, 4'd5, 4'd0, 1, 0, 1, 1, 0);
      push("halted", 1, 0, 0, 1, 1, 16'd3, 16'd2); sample();
      @(negedge clk); idle();
      push("halted_hold", 1, 0, 0, 1, 1, 16'd3, 16'd2); sample();

      doReset();
      @(negedge clk); drv(0, 4'd0, 4'd0, 4'd0, 0, 0, 0, 1, 0);
      push("halt2_id", 0, 0, 0, 0, 0, 16'd0, 16'd0); sample();
      @(negedge clk); idle();
      push("drain2_a", 1, 0, 0, 1, 0, 16'd0, 16'd0); sample();
      for (int i = 0; i < 2; i++) begin
         @(negedge clk); drv(0, 4'd0, 4'd0, 4'd0, 0, 0, 0, 0, 1);
         push("drain2_busy", 1, 1, 0, 1, 0, 16'd0, 16'd0); sample();
      end
      for (int i = 0; i < 2; i++) begin
         @(negedge clk); idle();
         push("drain2_b", 1, 0, 0, 1, 0, 16'd0, 16'd0); sample();
      end
      @(negedge clk); idle();
      push("halted2", 1, 0, 0, 1, 1, 16'd0, 16'd0); sample();

      doReset();
      @(negedge clk); drv(1, 4'd2, 4'd2, 4'd0, 1, 0, 0, 0, 0);
      push("pre_lu", 1, 0, 0, 1, 0, 16'd0, 16'd0); sample();
      @(negedge clk); drv(0, 4'd0, 4'd0, 4'd0, 0, 0, 1, 0, 0);
      push("pre_br", 0, 0, 1, 1, 0, 16'd1, 16'd0); sample();
      @(negedge clk); drv(0, 4'd0, 4'd0, 4'd0, 0, 0, 0, 1, 0);
      push("pre_halt", 0, 0, 0, 0, 0, 16'd1, 16'd1); sample();
      @(negedge clk); idle();
      push("pre_drain", 1, 0, 0, 1, 0, 16'd1, 16'd1); sample();
      @(negedge clk); idle();
      #1 rst = 1'b1;
      push("async_rst", 0, 0, 0, 0, 0, 16'd0, 16'd0); sample();
      @(negedge clk);
      rst = 1'b0;

      @(negedge clk); drv(1, 4'd6, 4'd0, 4'd6, 0, 1, 0, 0, 0);
      repeat (65539) @(posedge clk);
      @(negedge clk);
      push("sat", 1, 0, 0, 1, 0, 16'hFFFF, 16'd0); sample();
      @(negedge clk);
      push("sat_hold", 1, 0, 0, 1, 0, 16'hFFFF, 16'd0); sample();

      $display("%0d/%0d checks passed", passCnt, totalCnt);
      $finish;
   end

endmodule
